ppg_auto_calibrator: RTL
========================

// Module: ppg_auto_calibrator
// PURPOSE
//  Closed-loop calibration controller for the fingerclip PPG front end. It consumes the
//  8-bit Vppg sample and drives the 7-bit DC compensation and 4-bit PGA gain codes into
//  the fingerclip model. It searches DC_Comp until the baseline lands in a target window,
//  then raises PGA_Gain until the pulse peak-to-peak amplitude is adequate without clipping.
// PARAMETERS
//  SETTLE_CYCLES  16   cycles waited after any dc_comp/pga_gain change before sampling
//  MEAS_CYCLES    256  samples per min/max amplitude measurement window
//  DC_LO          96   lower bound of acceptable baseline (inclusive)
//  DC_HI          160  upper bound of acceptable baseline (inclusive)
//  P2P_TARGET     64   required peak-to-peak (max-min) amplitude
//  DC_MAX         127  largest dc_comp code
//  GAIN_MAX       15   largest pga_gain code
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  start      in   1  1-cycle pulse; starts calibration when not busy
//  vppg       in   8  PPG sample from fingerclip front end, unsigned
//  dc_comp    out  7  DC compensation code to front end
//  pga_gain   out  4  PGA gain code to front end
//  busy       out  1  high from accepted start until DONE/ERR
//  cal_done   out  1  level; calibration succeeded, codes valid
//  cal_error  out  1  level; calibration failed, codes hold last values
// BEHAVIOUR
//  - Reset (async, any state): dc_comp=0, pga_gain=0, busy=0, cal_done=0, cal_error=0, state IDLE,
//    counters/min/max cleared. Reset mid-calibration abandons the run with no completion flag.
//  - States: IDLE, DC_SETTLE, DC_CHECK, G_SETTLE, G_MEAS, G_EVAL, DONE, ERR.
//  - IDLE/DONE/ERR + start: dc_comp<=0, pga_gain<=0, cal_done<=0, cal_error<=0, busy<=1,
//    settle counter<=SETTLE_CYCLES-1, go DC_SETTLE. start while busy is ignored.
//  - DC_SETTLE: count down; at 0 go DC_CHECK (SETTLE_CYCLES cycles in state).
//  - DC_CHECK (one cycle, samples vppg):
//      DC_LO<=vppg<=DC_HI -> G_SETTLE.
//      vppg>DC_HI: dc_comp==DC_MAX -> ERR; else dc_comp+1 -> DC_SETTLE.
//      vppg<DC_LO: dc_comp==0 -> ERR; else dc_comp-1 (one step back, no retry) -> G_SETTLE.
//    One DC iteration = SETTLE_CYCLES+1 cycles.
//  - G_SETTLE: same countdown as DC_SETTLE, then clear min<=255, max<=0, go G_MEAS.
//  - G_MEAS: MEAS_CYCLES cycles; each cycle min<=min(min,vppg), max<=max(max,vppg). Then G_EVAL.
//  - G_EVAL (one cycle, compares the registered min/max; a sample of 255 or 0 is clipped):
//      max==255 or min==0: pga_gain==0 -> ERR; else pga_gain-1 -> DONE (no re-measure).
//      else (max-min)>=P2P_TARGET or pga_gain==GAIN_MAX -> DONE.
//      else pga_gain+1 -> G_SETTLE.
//    Subtraction max-min is 8-bit unsigned; max>=min is guaranteed after >=1 sample.
//  - DONE: busy=0, cal_done=1, codes held until next start or reset.
//  - ERR: busy=0, cal_error=1, codes held at their values when the error was detected.
//  - cal_done and cal_error are never both high. All outputs are registered.
//  - No wrap-around: dc_comp/pga_gain never inc past max or dec below 0 (guarded above).
// STRUCTURE
//  - Shared package ppg_pkg: state encoding, DC_W=7, GAIN_W=4, SAMPLE_W=8, default
//    DC_LO/DC_HI/P2P_TARGET constants (shared with the fingerclip model bench).
//  - One sub-module: ppg_peak_tracker (clr, en, vppg -> min, max) holding the window min/max.
//  - Settle and measurement counters are local, sized $clog2(MEAS_CYCLES)+1.
// TESTING (bench uses a behavioural fingerclip model driven by dc_comp/pga_gain)
//  1 vppg=200 while dc_comp<10, else 128 +- 10*(pga_gain+1) sine -> dc_comp=10; gain
//    climbs until p2p>=64: pga_gain=3 (p2p 80), cal_done=1, busy=0.
//  2 baseline 128 at dc_comp=0, flat signal (p2p=0) -> pga_gain=15 (GAIN_MAX), cal_done=1.
//  3 baseline ok, p2p=8*(g+1), clips at 255 when pga_gain>=5 -> pga_gain=4, cal_done=1.
//  4 vppg=50 constant from start -> cal_error=1 after SETTLE_CYCLES+1 cycles, dc_comp=0.
//  5 vppg=255 constant -> dc_comp steps to 127, then cal_error=1, pga_gain=0.
//  6 rst asserted during G_MEAS -> all outputs 0 asynchronously; start pulsed while busy
//    is ignored (pga_gain sequence unchanged); start after DONE restarts with codes=0.

Source files
------------

// File: rtl/ppg_pkg.sv
// Shared types and default thresholds for the fingerclip PPG calibration loop.
package ppg_pkg;

   localparam int unsigned DC_W     = 7;
   localparam int unsigned GAIN_W   = 4;
   localparam int unsigned SAMPLE_W = 8;

   localparam int unsigned DC_LO_DEF      = 96;
   localparam int unsigned DC_HI_DEF      = 160;
   localparam int unsigned P2P_TARGET_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DC_SETTLE,
      ST_DC_CHECK,
      ST_G_SETTLE,
      ST_G_MEAS,
      ST_G_EVAL,
      ST_DONE,
      ST_ERR
   } state_e;

endpackage

// File: rtl/ppg_peak_tracker.sv
// Running min/max of vppg over one measurement window; clr restarts the window.
module ppg_peak_tracker
   import ppg_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic [SAMPLE_W-1:0] vppg,
   output logic [SAMPLE_W-1:0] min_val,
   output logic [SAMPLE_W-1:0] max_val
);

   logic [SAMPLE_W-1:0] min_q, min_d;
   logic [SAMPLE_W-1:0] max_q, max_d;

   always_comb begin
      min_d = min_q;
      max_d = max_q;
      if (clr) begin
         min_d = '1;
         max_d = '0;
      end else if (en) begin
         if (vppg < min_q) min_d = vppg;
         if (vppg > max_q) max_d = vppg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q <= '1;
         max_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
      end
   end

   assign min_val = min_q;
   assign max_val = max_q;

endmodule

// File: rtl/ppg_auto_calibrator.sv
// Closed-loop DC-compensation search followed by PGA gain ramp for the PPG front end.
module ppg_auto_calibrator
   import ppg_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned MEAS_CYCLES   = 256,
   parameter int unsigned DC_LO         = DC_LO_DEF,
   parameter int unsigned DC_HI         = DC_HI_DEF,
   parameter int unsigned P2P_TARGET    = P2P_TARGET_DEF,
   parameter int unsigned DC_MAX        = 127,
   parameter int unsigned GAIN_MAX      = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SAMPLE_W-1:0] vppg,
   output logic [DC_W-1:0]     dc_comp,
   output logic [GAIN_W-1:0]   pga_gain,
   output logic                busy,
   output logic                cal_done,
   output logic                cal_error
);

   localparam int unsigned CNT_W = $clog2(MEAS_CYCLES) + 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DC_W-1:0]     dc_q, dc_d;
   logic [GAIN_W-1:0]   gain_q, gain_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                peak_clr_c, peak_en_c;
   logic [SAMPLE_W-1:0] pk_min, pk_max;
   logic [SAMPLE_W-1:0] p2p_c;

   ppg_peak_tracker u_peak (
      .clk     (clk),
      .rst     (rst),
      .clr     (peak_clr_c),
      .en      (peak_en_c),
      .vppg    (vppg),
      .min_val (pk_min),
      .max_val (pk_max)
   );

   assign p2p_c = pk_max - pk_min;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dc_d       = dc_q;
      gain_d     = gain_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      peak_clr_c = 1'b0;
      peak_en_c  = 1'b0;

      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               dc_d    = '0;
               gain_d  = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = ST_DC_SETTLE;
            end
         end
         ST_DC_SETTLE: begin
            if (cnt_q == '0) state_d = ST_DC_CHECK;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_DC_CHECK: begin
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
            if (vppg >= SAMPLE_W'(DC_LO) && vppg <= SAMPLE_W'(DC_HI)) begin
               state_d = ST_G_SETTLE;
            end else if (vppg > SAMPLE_W'(DC_HI)) begin
               if (dc_q == DC_W'(DC_MAX)) begin
                  state_d = ST_ERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  dc_d    = dc_q + DC_W'(1);
                  state_d = ST_DC_SETTLE;
               end
            end else begin
               // Overshot below the window: back off one step and accept it.
               if (dc_q == '0) begin
                  state_d = ST_ERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  dc_d    = dc_q - DC_W'(1);
                  state_d = ST_G_SETTLE;
               end
            end
         end
         ST_G_SETTLE: begin
            if (cnt_q == '0) begin
               peak_clr_c = 1'b1;
               cnt_d      = CNT_W'(MEAS_CYCLES - 1);
               state_d    = ST_G_MEAS;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_G_MEAS: begin
            peak_en_c = 1'b1;
            if (cnt_q == '0) state_d = ST_G_EVAL;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_G_EVAL: begin
            // A rail-valued sample means the previous gain step was too far.
            if (pk_max == '1 || pk_min == '0) begin
               if (gain_q == '0) begin
                  state_d = ST_ERR;
                  busy_d  = 1'b0;
                  err_d   = 1'b1;
               end else begin
                  gain_d  = gain_q - GAIN_W'(1);
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end else if (p2p_c >= SAMPLE_W'(P2P_TARGET) || gain_q == GAIN_W'(GAIN_MAX)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               gain_d  = gain_q + GAIN_W'(1);
               cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
               state_d = ST_G_SETTLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dc_q    <= '0;
         gain_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dc_q    <= dc_d;
         gain_q  <= gain_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign dc_comp   = dc_q;
   assign pga_gain  = gain_q;
   assign busy      = busy_q;
   assign cal_done  = done_q;
   assign cal_error = err_q;

endmodule
